// File: rtl/telem_packet_arbiter_if.sv
// Bundle of request/packet inputs and byte-stream downlink signals for telem_packet_arbiter.
// "slave" is the arbiter side; "master" is the sensor sources plus the downlink sink.
interface telem_packet_arbiter_if #(
  parameter int unsigned DROP_W = 8
);
  logic [2:0]        REQ;
  logic [79:0]       PKT0;
  logic [79:0]       PKT1;
  logic [79:0]       PKT2;
  logic [7:0]        TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic [2:0]        GRANT;
  logic              BUSY;
  logic [DROP_W-1:0] DROP_CNT;

  modport master (
    output REQ, PKT0, PKT1, PKT2, TX_READY,
    input  TX_DATA, TX_VALID, GRANT, BUSY, DROP_CNT
  );

  modport slave (
    input  REQ, PKT0, PKT1, PKT2, TX_READY,
    output TX_DATA, TX_VALID, GRANT, BUSY, DROP_CNT
  );
endinterface

// File: rtl/telem_packet_arbiter.sv
// Round-robin arbiter that buffers the latest packet of three sensor sources and serialises
// the granted one LSB-byte-first over a valid/ready byte stream.
module telem_packet_arbiter #(
  parameter int unsigned NUM_SRC   = 3,
  parameter int unsigned PKT_BYTES = 10,
  parameter int unsigned DROP_W    = 8
) (
  input logic                  CLK,
  input logic                  RESET,
  telem_packet_arbiter_if.slave bus
);
  localparam int unsigned PKT_W    = PKT_BYTES * 8;
  localparam logic [3:0]  LAST_IDX = 4'(PKT_BYTES - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e               r_state, w_state_nxt;
  logic [PKT_W-1:0]     r_buf [NUM_SRC];
  logic [PKT_W-1:0]     w_pkt [NUM_SRC];
  logic [NUM_SRC-1:0]   r_pend, w_pend_nxt, w_clr, w_ovr;
  logic [PKT_W-1:0]     r_shift, w_shift_nxt;
  logic [3:0]           r_idx, w_idx_nxt;
  logic [NUM_SRC-1:0]   r_grant, w_grant_nxt;
  logic [1:0]           r_last, w_last_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [DROP_W-1:0]    r_drop, w_drop_nxt;
  logic [DROP_W:0]      w_drop_sum;
  logic [1:0]           w_ovr_n;
  logic                 w_found;
  logic [1:0]           w_sel;

  assign w_pkt[0] = bus.PKT0;
  assign w_pkt[1] = bus.PKT1;
  assign w_pkt[2] = bus.PKT2;

  // Round-robin scan starting just after the last granted source.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    for (int k = 1; k <= int'(NUM_SRC); k++) begin
      if (!w_found && r_pend[(int'(r_last) + k) % NUM_SRC]) begin
        w_found = 1'b1;
        w_sel   = 2'((int'(r_last) + k) % NUM_SRC);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_valid_nxt = r_valid;
    w_clr       = '0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_nxt  = StSend;
          w_shift_nxt  = r_buf[w_sel];
          w_clr[w_sel] = 1'b1;
          w_grant_nxt  = NUM_SRC'(1) << w_sel;
          w_last_nxt   = w_sel;
          w_idx_nxt    = '0;
          w_valid_nxt  = 1'b1;
        end
      end
      StSend: begin
        if (r_valid && bus.TX_READY) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = StIdle;
            w_shift_nxt = '0;
            w_idx_nxt   = '0;
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
          end else begin
            w_shift_nxt = r_shift >> 8;
            w_idx_nxt   = r_idx + 4'd1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // A request only counts as a drop if the buffered packet is not being taken this cycle.
  always_comb begin
    w_pend_nxt = (r_pend & ~w_clr) | bus.REQ;
    w_ovr      = bus.REQ & r_pend & ~w_clr;
    w_ovr_n    = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      w_ovr_n = w_ovr_n + 2'(w_ovr[k]);
    end
    w_drop_sum = {1'b0, r_drop} + (DROP_W + 1)'(w_ovr_n);
    w_drop_nxt = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StIdle;
      r_pend  <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_last  <= 2'd2;
      r_valid <= 1'b0;
      r_drop  <= '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_valid_nxt;
      r_drop  <= w_drop_nxt;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (bus.REQ[i]) begin
          r_buf[i] <= w_pkt[i];
        end
      end
    end
  end

  assign bus.TX_DATA  = r_shift[7:0];
  assign bus.TX_VALID = r_valid;
  assign bus.GRANT    = r_grant;
  assign bus.BUSY     = (r_state == StSend);
  assign bus.DROP_CNT = r_drop;
endmodule

// File: tb/tb_telem_packet_arbiter.sv
// Scoreboard bench for telem_packet_arbiter: expected {grant, byte} pairs are queued when a
// request is driven and popped as the downlink accepts bytes.
module tb_telem_packet_arbiter;
  logic CLK = 1'b0;
  logic RESET = 1'b0;

  telem_packet_arbiter_if #(.DROP_W(8)) bus ();

  telem_packet_arbiter #(
    .NUM_SRC  (3),
    .PKT_BYTES(10),
    .DROP_W   (8)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial forever #5 CLK = ~CLK;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [10:0] sb_q[$];
  int          gap_q[$];
  int          hs_cnt  = 0;
  logic        rdy_mode  = 1'b0;
  logic        rdy_level = 1'b1;
  int          exp_drop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [79:0] mk_pkt(input logic [7:0] id);
    logic [79:0] p;
    p[31:0]  = $urandom();
    p[63:32] = $urandom();
    p[79:64] = 16'($urandom());
    p[7:0]   = id;
    return p;
  endfunction

  task automatic push_pkt(input logic [2:0] g, input logic [79:0] p);
    for (int b = 0; b < 10; b++) sb_q.push_back({g, p[b*8 +: 8]});
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic pulse_req(input logic [2:0] m);
    bus.REQ = m;
    @(posedge CLK);
    #1;
    bus.REQ = '0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    logic done = 1'b0;
    while (n < max && !done) begin
      @(posedge CLK);
      #1;
      n++;
      done = (sb_q.size() == 0) && !bus.BUSY && !bus.TX_VALID;
    end
    check_eq({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  // Sink ready: level or 1,0,0 pattern, updated 2 units after each rising edge.
  initial begin
    int ph = 0;
    bus.TX_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #2;
      if (rdy_mode) begin
        bus.TX_READY = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        bus.TX_READY = rdy_level;
        ph = 0;
      end
    end
  end

  // Monitor on the falling edge: handshakes, hold stability and inter-packet gaps.
  initial begin
    logic       held_v = 1'b0;
    logic [7:0] held_data = '0;
    logic [2:0] held_grant = '0;
    logic       prev_valid = 1'b0;
    int         idle_run = 0;
    logic [10:0] e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        if (held_v) begin
          check_eq("hold_valid", 32'(bus.TX_VALID), 32'd1);
          check_eq("hold_data", 32'(bus.TX_DATA), 32'(held_data));
          check_eq("hold_grant", 32'(bus.GRANT), 32'(held_grant));
        end
        if (bus.TX_VALID && !prev_valid) gap_q.push_back(idle_run);
        idle_run   = bus.TX_VALID ? 0 : idle_run + 1;
        prev_valid = bus.TX_VALID;
        if (bus.TX_VALID && bus.TX_READY) begin
          hs_cnt++;
          if (sb_q.size() == 0) begin
            check_eq("extra_byte", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check_eq("tx_grant_byte", 32'({bus.GRANT, bus.TX_DATA}), 32'(e));
          end
        end
        held_v     = bus.TX_VALID && !bus.TX_READY;
        held_data  = bus.TX_DATA;
        held_grant = bus.GRANT;
      end else begin
        held_v     = 1'b0;
        prev_valid = 1'b0;
        idle_run   = 0;
      end
    end
  end

  initial begin
    logic [79:0] pm, pg, pp, pa, pb;
    int hs0;
    int n;
    logic pend1;
    bus.REQ  = '0;
    bus.PKT0 = '0;
    bus.PKT1 = '0;
    bus.PKT2 = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_valid", 32'(bus.TX_VALID), 32'd0);
    check_eq("rst_grant", 32'(bus.GRANT), 32'd0);
    check_eq("rst_busy", 32'(bus.BUSY), 32'd0);
    check_eq("rst_drop", 32'(bus.DROP_CNT), 32'd0);
    check_eq("rst_data", 32'(bus.TX_DATA), 32'd0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Single mag packet with known contents and first-byte latency.
    pm = 80'h0096_0032_0000_00012C_4D;
    bus.PKT0 = pm;
    push_pkt(3'b001, pm);
    pulse_req(3'b001);
    check_eq("lat_capture_valid", 32'(bus.TX_VALID), 32'd0);
    @(posedge CLK);
    #1;
    check_eq("lat_select_valid", 32'(bus.TX_VALID), 32'd1);
    check_eq("lat_select_grant", 32'(bus.GRANT), 32'b001);
    check_eq("first_byte", 32'(bus.TX_DATA), 32'h4D);
    wait_idle("single", 40);
    check_eq("idle_data", 32'(bus.TX_DATA), 32'd0);
    check_eq("idle_grant", 32'(bus.GRANT), 32'd0);

    // Pressure alone so the next burst scan starts at mag.
    pp = mk_pkt(8'hC3);
    bus.PKT2 = pp;
    push_pkt(3'b100, pp);
    pulse_req(3'b100);
    wait_idle("press_alone", 40);

    pm = mk_pkt(8'hA1); pg = mk_pkt(8'hB2); pp = mk_pkt(8'hC3);
    bus.PKT0 = pm; bus.PKT1 = pg; bus.PKT2 = pp;
    push_pkt(3'b001, pm); push_pkt(3'b010, pg); push_pkt(3'b100, pp);
    gap_q.delete();
    pulse_req(3'b111);
    wait_idle("burst1", 100);
    check_eq("burst1_starts", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      check_eq("burst1_gap1", 32'(gap_q[1]), 32'd1);
      check_eq("burst1_gap2", 32'(gap_q[2]), 32'd1);
    end

    // Gyro-last grant: next burst must begin with pressure.
    pg = mk_pkt(8'hB2);
    bus.PKT1 = pg;
    push_pkt(3'b010, pg);
    pulse_req(3'b010);
    wait_idle("gyro_alone", 40);
    pm = mk_pkt(8'hA1); pg = mk_pkt(8'hB2); pp = mk_pkt(8'hC3);
    bus.PKT0 = pm; bus.PKT1 = pg; bus.PKT2 = pp;
    push_pkt(3'b100, pp); push_pkt(3'b001, pm); push_pkt(3'b010, pg);
    pulse_req(3'b111);
    wait_idle("burst2", 100);

    // Back-pressure with ready pattern 1,0,0.
    rdy_mode = 1'b1;
    hs0 = hs_cnt;
    pp = mk_pkt(8'hC3);
    bus.PKT2 = pp;
    push_pkt(3'b100, pp);
    pulse_req(3'b100);
    wait_idle("bp", 100);
    check_eq("bp_handshakes", 32'(hs_cnt - hs0), 32'd10);
    rdy_mode = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Gyro overwritten during a mag transfer: only B goes out.
    pm = mk_pkt(8'hA1); pa = mk_pkt(8'hB2); pb = mk_pkt(8'hB2);
    bus.PKT0 = pm;
    push_pkt(3'b001, pm); push_pkt(3'b010, pb);
    pulse_req(3'b001);
    bus.PKT1 = pa;
    pulse_req(3'b010);
    bus.PKT1 = pb;
    pulse_req(3'b010);
    check_eq("drop_one", 32'(bus.DROP_CNT), 32'd1);
    wait_idle("drop", 60);
    exp_drop = 1;

    // Saturation: stall the sink and hammer gyro requests.
    rdy_level = 1'b0;
    @(posedge CLK);
    #1;
    pm = mk_pkt(8'hA1);
    bus.PKT0 = pm;
    push_pkt(3'b001, pm);
    pulse_req(3'b001);
    @(posedge CLK);
    #1;
    check_eq("sat_busy", 32'(bus.BUSY), 32'd1);
    pend1 = 1'b0;
    for (int i = 0; i < 301; i++) begin
      pg = mk_pkt(8'hB2);
      bus.PKT1 = pg;
      bus.REQ = 3'b010;
      @(posedge CLK);
      #1;
      if (pend1 && exp_drop < 255) exp_drop++;
      pend1 = 1'b1;
      if (i == 99) check_eq("drop_mid", 32'(bus.DROP_CNT), 32'(exp_drop));
    end
    bus.REQ = '0;
    check_eq("drop_sat", 32'(bus.DROP_CNT), 32'hFF);
    check_eq("drop_model", 32'(bus.DROP_CNT), 32'(exp_drop));
    push_pkt(3'b010, pg);
    rdy_level = 1'b1;
    wait_idle("sat", 200);

    // Reset asserted mid-packet after the fourth byte.
    pm = mk_pkt(8'hA1);
    bus.PKT0 = pm;
    push_pkt(3'b001, pm);
    hs0 = hs_cnt;
    pulse_req(3'b001);
    n = 0;
    while (hs_cnt - hs0 < 4 && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check_eq("mid_bytes", 32'(hs_cnt - hs0), 32'd4);
    #2;
    RESET = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(bus.TX_VALID), 32'd0);
    check_eq("mid_rst_grant", 32'(bus.GRANT), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.BUSY), 32'd0);
    check_eq("mid_rst_drop", 32'(bus.DROP_CNT), 32'd0);
    sb_q.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    hs0 = hs_cnt;
    repeat (30) @(posedge CLK);
    #1;
    check_eq("post_rst_bytes", 32'(hs_cnt - hs0), 32'd0);
    check_eq("post_rst_busy", 32'(bus.BUSY), 32'd0);
    check_eq("post_rst_valid", 32'(bus.TX_VALID), 32'd0);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
